prf_nway: RTL and testbench

Parametrised N-way physical register file with an integrated free list for the superscalar out-of-order core. It is the generalised successor of the fixed 2-way PRF. It serves WAYS rename allocations per cycle, CDB_NUM writebacks with same-cycle read bypass, and WAYS retire frees. It also performs single-cycle mispredict recovery from a free mask and sets up the initial architectural mapping on reset.

---
 rtl/prf_nway.sv | 154 +++++++++++++++
 tb/tb_prf_nway.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_nway.sv
// N-way physical register file with integrated free list: WAYS in-order
// allocations, CDB_NUM writebacks with read bypass, WAYS retire frees,
// single-cycle mask recovery.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   cdb_valid/tag/data        writeback ports (higher port wins on a tag clash)
//   rd_idx -> rd_value/valid  combinational operand reads with CDB bypass
//   alloc_req -> alloc_valid/idx  combinational in-order grants
//   free_valid/free_idx       retire frees
//   recover_valid/mask        mispredict recovery (mask bit = free entry)
//   free_count                registered count of FREE entries
module prf_nway #(
  parameter int PRF_SIZE    = 64,
  parameter int DATA_W      = 64,
  parameter int WAYS        = 2,
  parameter int CDB_NUM     = 2,
  parameter int READ_PORTS  = 4,
  parameter int RESET_ALLOC = 32,
  parameter int IDX_W       = $clog2(PRF_SIZE)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CDB_NUM-1:0]           cdb_valid,
  input  logic [CDB_NUM*IDX_W-1:0]     cdb_tag,
  input  logic [CDB_NUM*DATA_W-1:0]    cdb_data,
  input  logic [READ_PORTS*IDX_W-1:0]  rd_idx,
  output logic [READ_PORTS*DATA_W-1:0] rd_value,
  output logic [READ_PORTS-1:0]        rd_valid,
  input  logic [WAYS-1:0]              alloc_req,
  output logic [WAYS-1:0]              alloc_valid,
  output logic [WAYS*IDX_W-1:0]        alloc_idx,
  input  logic [WAYS-1:0]              free_valid,
  input  logic [WAYS*IDX_W-1:0]        free_idx,
  input  logic                         recover_valid,
  input  logic [PRF_SIZE-1:0]          recover_mask,
  output logic [IDX_W:0]               free_count
);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_BUSY  = 2'd1,
    S_READY = 2'd2
  } ent_e;

  ent_e              st_q  [PRF_SIZE];
  logic [DATA_W-1:0] dat_q [PRF_SIZE];

  logic [PRF_SIZE-1:0] taken;
  logic [PRF_SIZE-1:0] kill;
  logic [IDX_W:0]      n_grant;
  logic [IDX_W:0]      n_freed;
  logic                blocked;
  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    ri;

  // Grant scan over registered state only. A failed requesting slot
  // blocks every later slot so grants stay in program order.
  always_comb begin
    taken       = '0;
    blocked     = 1'b0;
    found       = 1'b0;
    pick        = '0;
    n_grant     = '0;
    alloc_valid = '0;
    alloc_idx   = '0;
    for (int k = 0; k < WAYS; k++) begin
      found = 1'b0;
      pick  = '0;
      if (alloc_req[k] && !blocked && !recover_valid && !reset) begin
        for (int e = 0; e < PRF_SIZE; e++) begin
          if (!found && st_q[e] == S_FREE && !taken[e]) begin
            found = 1'b1;
            pick  = IDX_W'(e);
          end
        end
        if (found) begin
          alloc_valid[k]                = 1'b1;
          alloc_idx[k*IDX_W +: IDX_W]   = pick;
          taken[pick]                   = 1'b1;
          n_grant = n_grant + (IDX_W+1)'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // Entries released this edge by recovery or retire.
  always_comb begin
    kill    = recover_valid ? recover_mask : '0;
    n_freed = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (free_valid[k]) begin
        kill[free_idx[k*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    for (int e = 0; e < PRF_SIZE; e++) begin
      if (kill[e] && st_q[e] != S_FREE) begin
        n_freed = n_freed + (IDX_W+1)'(1);
      end
    end
  end

  // Reads: storage first, then any matching CDB port overrides;
  // the later (higher) port wins, matching the write priority.
  always_comb begin
    rd_value = '0;
    rd_valid = '0;
    ri       = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      ri = rd_idx[r*IDX_W +: IDX_W];
      rd_value[r*DATA_W +: DATA_W] = dat_q[ri];
      rd_valid[r] = (st_q[ri] == S_READY);
      for (int p = 0; p < CDB_NUM; p++) begin
        if (cdb_valid[p] && cdb_tag[p*IDX_W +: IDX_W] == ri) begin
          rd_value[r*DATA_W +: DATA_W] =
            cdb_data[p*DATA_W +: DATA_W];
          rd_valid[r] = 1'b1;
        end
      end
    end
  end

  // Later assignments override earlier ones: kill > CDB > allocate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < PRF_SIZE; e++) begin
        st_q[e]  <= (e < RESET_ALLOC) ? S_READY : S_FREE;
        dat_q[e] <= '0;
      end
      free_count <= (IDX_W+1)'(PRF_SIZE - RESET_ALLOC);
    end else begin
      for (int e = 0; e < PRF_SIZE; e++) begin
        if (taken[e]) st_q[e] <= S_BUSY;
      end
      for (int p = 0; p < CDB_NUM; p++) begin
        if (cdb_valid[p] &&
            st_q[cdb_tag[p*IDX_W +: IDX_W]] != S_FREE &&
            !kill[cdb_tag[p*IDX_W +: IDX_W]]) begin
          dat_q[cdb_tag[p*IDX_W +: IDX_W]] <=
            cdb_data[p*DATA_W +: DATA_W];
          st_q[cdb_tag[p*IDX_W +: IDX_W]] <= S_READY;
        end
      end
      for (int e = 0; e < PRF_SIZE; e++) begin
        if (kill[e]) st_q[e] <= S_FREE;
      end
      free_count <= free_count + n_freed - n_grant;
    end
  end

endmodule

// File: tb/tb_prf_nway.sv
// Scoreboard bench for prf_nway: driver pushes model expectations,
// negedge monitor pops and compares against the DUT outputs.
module tb_prf_nway;
  localparam int PRF_SIZE    = 64;
  localparam int DATA_W      = 64;
  localparam int WAYS        = 2;
  localparam int CDB_NUM     = 2;
  localparam int READ_PORTS  = 4;
  localparam int RESET_ALLOC = 32;
  localparam int IDX_W       = 6;

  logic                         clock;
  logic                         reset;
  logic [CDB_NUM-1:0]           cdb_valid;
  logic [CDB_NUM*IDX_W-1:0]     cdb_tag;
  logic [CDB_NUM*DATA_W-1:0]    cdb_data;
  logic [READ_PORTS*IDX_W-1:0]  rd_idx;
  logic [READ_PORTS*DATA_W-1:0] rd_value;
  logic [READ_PORTS-1:0]        rd_valid;
  logic [WAYS-1:0]              alloc_req;
  logic [WAYS-1:0]              alloc_valid;
  logic [WAYS*IDX_W-1:0]        alloc_idx;
  logic [WAYS-1:0]              free_valid;
  logic [WAYS*IDX_W-1:0]        free_idx;
  logic                         recover_valid;
  logic [PRF_SIZE-1:0]          recover_mask;
  logic [IDX_W:0]               free_count;

  prf_nway #(
    .PRF_SIZE(PRF_SIZE), .DATA_W(DATA_W), .WAYS(WAYS),
    .CDB_NUM(CDB_NUM), .READ_PORTS(READ_PORTS),
    .RESET_ALLOC(RESET_ALLOC), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_valid(rd_valid),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx),
    .recover_valid(recover_valid), .recover_mask(recover_mask),
    .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: 0 = free, 1 = busy, 2 = ready.
  int                mst  [PRF_SIZE];
  logic [DATA_W-1:0] mdat [PRF_SIZE];
  int                mfc;
  logic [WAYS-1:0]   g_valid;
  int                g_idx [WAYS];

  typedef struct {
    logic [WAYS-1:0]              av;
    logic [WAYS*IDX_W-1:0]        ai;
    logic [IDX_W:0]               fc;
    logic [READ_PORTS*DATA_W-1:0] rv;
    logic [READ_PORTS-1:0]        rvl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic model_reset();
    for (int e = 0; e < PRF_SIZE; e++) begin
      mst[e]  = (e < RESET_ALLOC) ? 2 : 0;
      mdat[e] = '0;
    end
    mfc = PRF_SIZE - RESET_ALLOC;
  endtask

  task automatic push_expected();
    exp_t x;
    int   pool[$];
    bit   stop;
    int   idx;
    for (int e = 0; e < PRF_SIZE; e++)
      if (mst[e] == 0) pool.push_back(e);
    stop = reset || recover_valid;
    x.av = '0;
    x.ai = '0;
    for (int k = 0; k < WAYS; k++) begin
      g_valid[k] = 1'b0;
      g_idx[k]   = 0;
      if (alloc_req[k] && !stop) begin
        if (pool.size() == 0) begin
          stop = 1'b1;
        end else begin
          g_idx[k]   = pool.pop_front();
          g_valid[k] = 1'b1;
          x.av[k]    = 1'b1;
          x.ai[k*IDX_W +: IDX_W] = IDX_W'(g_idx[k]);
        end
      end
    end
    x.fc  = (IDX_W+1)'(mfc);
    x.rv  = '0;
    x.rvl = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      idx = int'(rd_idx[r*IDX_W +: IDX_W]);
      x.rv[r*DATA_W +: DATA_W] = mdat[idx];
      x.rvl[r] = (mst[idx] == 2);
      for (int p = 0; p < CDB_NUM; p++) begin
        if (cdb_valid[p] && int'(cdb_tag[p*IDX_W +: IDX_W]) == idx) begin
          x.rv[r*DATA_W +: DATA_W] = cdb_data[p*DATA_W +: DATA_W];
          x.rvl[r] = 1'b1;
        end
      end
    end
    q.push_back(x);
  endtask

  task automatic update_model();
    int pre  [PRF_SIZE];
    bit kill [PRF_SIZE];
    int became;
    int t;
    if (reset) begin
      model_reset();
      return;
    end
    for (int e = 0; e < PRF_SIZE; e++) begin
      pre[e]  = mst[e];
      kill[e] = recover_valid && recover_mask[e];
    end
    for (int k = 0; k < WAYS; k++)
      if (free_valid[k]) kill[int'(free_idx[k*IDX_W +: IDX_W])] = 1'b1;
    became = 0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      if (kill[e]) begin
        if (pre[e] != 0) became++;
        mst[e] = 0;
      end
    end
    for (int p = 0; p < CDB_NUM; p++) begin
      t = int'(cdb_tag[p*IDX_W +: IDX_W]);
      if (cdb_valid[p] && !kill[t] && pre[t] != 0) begin
        mdat[t] = cdb_data[p*DATA_W +: DATA_W];
        mst[t]  = 2;
      end
    end
    for (int k = 0; k < WAYS; k++) begin
      if (g_valid[k] && !kill[g_idx[k]]) begin
        mst[g_idx[k]] = 1;
        mfc--;
      end
    end
    mfc = mfc + became;
  endtask

  task automatic idle();
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_data      = '0;
    rd_idx        = '0;
    alloc_req     = '0;
    free_valid    = '0;
    free_idx      = '0;
    recover_valid = 1'b0;
    recover_mask  = '0;
  endtask

  task automatic step();
    push_expected();
    @(posedge clock);
    #1;
    update_model();
  endtask

  task automatic set_rd(input int r, input int idx);
    rd_idx[r*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (alloc_valid !== x.av) begin
        errors++;
        $display("FAIL alloc_valid t=%0t got=%b exp=%b",
                 $time, alloc_valid, x.av);
      end
      checks++;
      if (alloc_idx !== x.ai) begin
        errors++;
        $display("FAIL alloc_idx t=%0t got=%h exp=%h",
                 $time, alloc_idx, x.ai);
      end
      checks++;
      if (free_count !== x.fc) begin
        errors++;
        $display("FAIL free_count t=%0t got=%0d exp=%0d",
                 $time, free_count, x.fc);
      end
      for (int r = 0; r < READ_PORTS; r++) begin
        checks++;
        if (rd_valid[r] !== x.rvl[r]) begin
          errors++;
          $display("FAIL rd_valid[%0d] t=%0t got=%b exp=%b",
                   r, $time, rd_valid[r], x.rvl[r]);
        end
        checks++;
        if (rd_value[r*DATA_W +: DATA_W] !== x.rv[r*DATA_W +: DATA_W]) begin
          errors++;
          $display("FAIL rd_value[%0d] t=%0t got=%h exp=%h", r, $time,
                   rd_value[r*DATA_W +: DATA_W], x.rv[r*DATA_W +: DATA_W]);
        end
      end
    end
  end

  initial begin
    int busy[$];
    int guard;
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;

    // 1: reset image, then in-order allocation 32, 33/34
    reset = 1'b0;
    set_rd(0, 0); set_rd(1, 40); set_rd(2, 31); set_rd(3, 32);
    step();
    idle(); alloc_req = 2'b01; step();
    idle(); alloc_req = 2'b11; step();
    idle(); step();

    // 2: bypass then storage read
    do_reset();
    idle(); alloc_req = 2'b01; step();
    idle();
    cdb_valid = 2'b01;
    cdb_tag[0 +: IDX_W] = 6'd32;
    cdb_data[0 +: DATA_W] = 64'hDEAD_BEEF;
    set_rd(0, 32);
    step();
    idle(); set_rd(0, 32); step();

    // 3: exhaust the free list
    guard = 0;
    while (mfc > 2 && guard < 100) begin
      idle(); alloc_req = 2'b11; step(); guard++;
    end
    if (mfc == 2) begin
      idle(); alloc_req = 2'b01; step();
    end
    idle(); alloc_req = 2'b11; step();
    idle(); alloc_req = 2'b11; step();
    idle(); alloc_req = 2'b11; step();

    // 4: freed entry not allocatable in the same cycle
    do_reset();
    idle();
    free_valid = 2'b01;
    free_idx[0 +: IDX_W] = 6'd5;
    alloc_req = 2'b01;
    step();
    idle(); alloc_req = 2'b01; set_rd(0, 5); step();

    // 5: recovery blocks grants and frees masked entries
    do_reset();
    idle(); alloc_req = 2'b01; step();
    idle(); alloc_req = 2'b11; step();
    idle(); alloc_req = 2'b01; step();
    idle();
    recover_valid = 1'b1;
    recover_mask[35:33] = 3'b111;
    alloc_req = 2'b11;
    step();
    idle(); alloc_req = 2'b01; set_rd(0, 32); set_rd(1, 34); step();

    // 6: asynchronous reset between edges
    idle(); alloc_req = 2'b11; step();
    idle();
    reset = 1'b1;
    model_reset();
    set_rd(0, 0); set_rd(1, 40);
    step();
    reset = 1'b0;
    idle(); set_rd(0, 0); set_rd(1, 40); step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      alloc_req = WAYS'($urandom);
      busy.delete();
      for (int e = 0; e < PRF_SIZE; e++)
        if (mst[e] != 0) busy.push_back(e);
      for (int p = 0; p < CDB_NUM; p++) begin
        cdb_valid[p] = ($urandom_range(0, 1) == 1);
        if (busy.size() > 0 && $urandom_range(0, 3) != 0)
          cdb_tag[p*IDX_W +: IDX_W] =
            IDX_W'(busy[$urandom_range(0, busy.size() - 1)]);
        else
          cdb_tag[p*IDX_W +: IDX_W] = IDX_W'($urandom);
        cdb_data[p*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      for (int k = 0; k < WAYS; k++) begin
        if (busy.size() > 0 && $urandom_range(0, 2) == 0) begin
          free_valid[k] = 1'b1;
          free_idx[k*IDX_W +: IDX_W] =
            IDX_W'(busy[$urandom_range(0, busy.size() - 1)]);
        end
      end
      if ($urandom_range(0, 31) == 0) begin
        recover_valid = 1'b1;
        recover_mask = {$urandom, $urandom};
      end
      for (int r = 0; r < READ_PORTS; r++)
        set_rd(r, int'($urandom_range(0, PRF_SIZE - 1)));
      if ($urandom_range(0, 1) == 1)
        rd_idx[0 +: IDX_W] = cdb_tag[0 +: IDX_W];
      step();
    end

    idle();
    repeat (2) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
